// File: rtl/tug_of_war_match.sv
// Tug-of-war match engine: one lit position pushed by two players,
// with point scoring, a dark pause between rounds and a match winner.
module tug_of_war_match #(
    parameter int NUM_LIGHTS  = 9,
    parameter int WIN_SCORE   = 3,
    parameter int ROUND_DELAY = 4
) (
    input  logic                           clk,
    input  logic                           Reset,
    input  logic                           restart,
    input  logic                           right_press,
    input  logic                           left_press,
    output logic [NUM_LIGHTS-1:0]          leds,
    output logic [$clog2(WIN_SCORE+1)-1:0] r_score,
    output logic [$clog2(WIN_SCORE+1)-1:0] l_score,
    output logic                           point_pulse,
    output logic                           match_over,
    output logic [1:0]                     winner
);

    localparam int PW = $clog2(NUM_LIGHTS);
    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int DW = $clog2(ROUND_DELAY + 1);

    localparam logic [PW-1:0] CENTER     = PW'(NUM_LIGHTS / 2);
    localparam logic [PW-1:0] RIGHT_END  = '0;
    localparam logic [PW-1:0] LEFT_END   = PW'(NUM_LIGHTS - 1);
    localparam logic [SW-1:0] WIN        = SW'(WIN_SCORE);
    localparam logic [DW-1:0] DELAY_LOAD = DW'(ROUND_DELAY - 1);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_R    = 2'b01;
    localparam logic [1:0] WIN_L    = 2'b10;

    typedef enum logic [1:0] {
        S_PLAY,
        S_POINT,
        S_OVER
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [SW-1:0] r_score_q, r_score_d;
    logic [SW-1:0] l_score_q, l_score_d;
    logic [DW-1:0] delay_q, delay_d;
    logic          pulse_q, pulse_d;
    logic [1:0]    winner_q, winner_d;
    logic          r_prev_q, r_prev_d;
    logic          l_prev_q, l_prev_d;

    logic          clear;
    logic          r_edge;
    logic          l_edge;
    logic          score_r;
    logic          score_l;

    assign clear  = Reset | restart;
    assign r_edge = right_press & ~r_prev_q;
    assign l_edge = left_press & ~l_prev_q;

    // Next-state: light movement, scoring, round pause and match end
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        r_score_d = r_score_q;
        l_score_d = l_score_q;
        delay_d   = delay_q;
        pulse_d   = 1'b0;
        winner_d  = winner_q;
        r_prev_d  = right_press;
        l_prev_d  = left_press;
        score_r   = 1'b0;
        score_l   = 1'b0;

        unique case (state_q)
            S_PLAY: begin
                if (r_edge && !l_edge) begin
                    if (pos_q == RIGHT_END) begin
                        score_r = 1'b1;
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end else if (l_edge && !r_edge) begin
                    if (pos_q == LEFT_END) begin
                        score_l = 1'b1;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end

                if (score_r) begin
                    pulse_d   = 1'b1;
                    r_score_d = r_score_q + SW'(1);
                    if (r_score_d == WIN) begin
                        state_d  = S_OVER;
                        winner_d = WIN_R;
                    end else begin
                        state_d = S_POINT;
                        delay_d = DELAY_LOAD;
                    end
                end else if (score_l) begin
                    pulse_d   = 1'b1;
                    l_score_d = l_score_q + SW'(1);
                    if (l_score_d == WIN) begin
                        state_d  = S_OVER;
                        winner_d = WIN_L;
                    end else begin
                        state_d = S_POINT;
                        delay_d = DELAY_LOAD;
                    end
                end
            end
            S_POINT: begin
                if (delay_q == '0) begin
                    pos_d   = CENTER;
                    state_d = S_PLAY;
                end else begin
                    delay_d = delay_q - DW'(1);
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_PLAY;
                pos_d   = CENTER;
            end
        endcase
    end

    // State registers; Reset or restart returns everything to match start
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= S_PLAY;
            pos_q     <= CENTER;
            r_score_q <= '0;
            l_score_q <= '0;
            delay_q   <= '0;
            pulse_q   <= 1'b0;
            winner_q  <= WIN_NONE;
            r_prev_q  <= 1'b1;
            l_prev_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            r_score_q <= r_score_d;
            l_score_q <= l_score_d;
            delay_q   <= delay_d;
            pulse_q   <= pulse_d;
            winner_q  <= winner_d;
            r_prev_q  <= r_prev_d;
            l_prev_q  <= l_prev_d;
        end
    end

    // Bar display follows the state: lit position, dark, or all lit
    always_comb begin
        leds = '0;
        unique case (state_q)
            S_PLAY:  leds = NUM_LIGHTS'(1) << pos_q;
            S_POINT: leds = '0;
            S_OVER:  leds = '1;
            default: leds = '0;
        endcase
    end

    assign r_score     = r_score_q;
    assign l_score     = l_score_q;
    assign point_pulse = pulse_q;
    assign match_over  = (state_q == S_OVER);
    assign winner      = winner_q;

endmodule
